uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCKS_PER_BAUD, default 868, system clocks per bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame; fixed 8N1 framing.
REQ-003 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx  input  1  raw serial line from the FPGA pin; asynchronous; idle high.
REQ-006 data_out  output  DATA_BITS  last received byte, LSB = first data bit on the wire.
REQ-007 valid_out  output  1  single-cycle strobe; data_out is new and good.
REQ-008 frame_err_out  output  1  single-cycle strobe; stop bit was sampled low.
REQ-009 busy_out  output  1  high whenever the state is not IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer before any use; the synchronized signal is rx_s.
REQ-011 The FSM SHALL have the states IDLE, START, DATA, STOP and BREAK.
REQ-012 IDLE: when rx_s == 0, the FSM SHALL clear the baud counter and go to START; otherwise it SHALL hold.
REQ-013 START: when the counter reaches CLOCKS_PER_BAUD/2 - 1 (integer division), the FSM SHALL sample rx_s; 1 -> IDLE (glitch rejected, no strobe); 0 -> DATA with counter and bit index cleared.
REQ-014 DATA: on every counter value CLOCKS_PER_BAUD - 1, the FSM SHALL sample rx_s, shift it in at the MSB of the shift register (LSB-first wire order), increment the bit index and clear the counter; after DATA_BITS samples it SHALL go to STOP.
REQ-015 STOP: on counter value CLOCKS_PER_BAUD - 1, the FSM SHALL sample rx_s; 1 -> load data_out, pulse valid_out, go to IDLE; 0 -> pulse frame_err_out, leave data_out unchanged, go to BREAK.
REQ-016 BREAK: the FSM SHALL hold until rx_s == 1, then go to IDLE; no new start is detected while the line is held low.
REQ-017 valid_out and frame_err_out SHALL be registered, high for exactly one clock, and never high in the same cycle.
REQ-018 Latency: valid_out SHALL rise on the clock after the stop sample, i.e. at 2 (sync) + CLOCKS_PER_BAUD/2 + (DATA_BITS+1)*CLOCKS_PER_BAUD + 1 clocks after the rx falling edge reaches the pin, within ±1 clock.
REQ-019 data_out SHALL hold its value until the next valid_out.
REQ-020 A falling edge during the STOP→IDLE cycle SHALL be detected in IDLE on the next clock; back-to-back frames SHALL lose no byte.
REQ-021 The baud counter SHALL be $clog2(CLOCKS_PER_BAUD) bits wide and SHALL never wrap past CLOCKS_PER_BAUD - 1.

Reset
REQ-022 On rst_n low, the FSM SHALL go to IDLE and the synchronizer flops SHALL be set to 1.
REQ-023 On rst_n low, data_out, the shift register, the counter, the bit index, valid_out, frame_err_out and busy_out SHALL all be 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no strobe; after release, reception SHALL resume at the next falling edge of rx_s.

Structure
REQ-025 Package uart_pkg SHALL hold the FSM state enum typedef and the default CLOCKS_PER_BAUD constant, for sharing with the matching transmitter.
REQ-026 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, with a parameterized reset value (1 here).
REQ-027 An elaboration-time check SHALL reject CLOCKS_PER_BAUD < 4.

Verification (CLOCKS_PER_BAUD = 8)
REQ-028 Frame 0xA5 with a good stop bit -> exactly one valid_out with data_out = 0xA5, at the clock given by REQ-018 (±1); frame_err_out stays 0.
REQ-029 Frames 0x00, 0xFF, 0x3C back-to-back with no idle gap -> three valid_out pulses, in order, with matching data.
REQ-030 A 2-clock low glitch on idle rx -> FSM returns to IDLE from START; no valid_out and no frame_err_out.
REQ-031 Frame 0x55 with the stop bit low, line then held low for 40 clocks -> one frame_err_out, data_out unchanged, busy_out high until rx returns high, then a following 0x12 frame is received correctly.
REQ-032 rst_n pulsed low during data bit 4 of frame 0x81 -> no strobe and all outputs 0; the next frame, 0x42, is received correctly.
REQ-033 Sampling point swept over rx bit-period errors of ±3% -> every byte is still received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default baud divider.
// Also used by the matching transmitter.
package uart_pkg;

  localparam int unsigned DEF_CLOCKS_PER_BAUD = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset to RST_VAL so an idle line reads idle out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, framing error and break handling.
// Strobes are registered and mutually exclusive.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BAUD = DEF_CLOCKS_PER_BAUD,
  parameter int unsigned DATA_BITS       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 frame_err_out,
  output logic                 busy_out
);

  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  if (CLOCKS_PER_BAUD < 4) begin : g_bad_cpb
    $error("uart_rx: CLOCKS_PER_BAUD must be at least 4");
  end

  rx_state_e state, next_state;

  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;

  logic cnt_clr, cnt_inc, idx_clr, shift_en, load, err;
  logic half_hit, full_hit;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign half_hit = (cnt == HALF_M1);
  assign full_hit = (cnt == FULL_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (!rx_s) next_state = START;
      START: if (half_hit) next_state = rx_s ? IDLE : DATA;
      DATA:  if (full_hit && idx == LAST_BIT) next_state = STOP;
      STOP:  if (full_hit) next_state = rx_s ? IDLE : BREAK;
      BREAK: if (rx_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    idx_clr  = 1'b0;
    shift_en = 1'b0;
    load     = 1'b0;
    err      = 1'b0;
    unique case (state)
      IDLE: cnt_clr = !rx_s;
      START: begin
        cnt_inc = !half_hit;
        cnt_clr = half_hit;
        idx_clr = half_hit;
      end
      DATA: begin
        cnt_inc  = !full_hit;
        cnt_clr  = full_hit;
        shift_en = full_hit;
      end
      STOP: begin
        cnt_inc = !full_hit;
        cnt_clr = full_hit;
        load    = full_hit && rx_s;
        err     = full_hit && !rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (idx_clr)       idx <= '0;
      else if (shift_en) idx <= idx + 1'b1;
      // LSB arrives first, so shifting in at the MSB lands it at bit 0
      if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (load) data_out <= shreg;
      valid_out     <= load;
      frame_err_out <= err;
    end
  end

  assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx at CLOCKS_PER_BAUD = 8.
// Compares received strobes against an expected-event queue.
module tb_uart_rx;

  localparam int CPB  = 8;
  localparam int TCLK = 1000;
  localparam int LAT  = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       frame_err_out;
  logic       busy_out;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int fall_cyc = 0;

  logic [8:0] exp_q[$];
  logic [8:0] ev_q[$];
  int         ev_cyc[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(
    .CLOCKS_PER_BAUD (CPB),
    .DATA_BITS       (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .frame_err_out (frame_err_out),
    .busy_out      (busy_out)
  );

  always #(TCLK / 2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && (valid_out || frame_err_out)) begin
      chk("strobe_excl", {31'd0, valid_out & frame_err_out}, 0);
      ev_q.push_back({frame_err_out, data_out});
      ev_cyc.push_back(cyc);
    end
  end

  task automatic align();
    @(posedge clk);
    #130;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int bit_t);
    exp_q.push_back(stop ? {1'b0, b} : {1'b1, last_good});
    if (stop) last_good = b;
    rx = 1'b0;
    fall_cyc = cyc;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_t);
    end
    rx = stop;
    #(bit_t);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, ev_q.size(), exp_q.size());
    while (ev_q.size() > 0 && exp_q.size() > 0)
      chk(tag, {23'd0, ev_q.pop_front()}, {23'd0, exp_q.pop_front()});
    ev_q.delete();
    exp_q.delete();
    ev_cyc.delete();
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(posedge clk);
  endtask

  initial begin
    int lat;
    int bt;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #130;
    chk("rst_data", {24'd0, data_out}, 0);
    chk("rst_valid", {31'd0, valid_out}, 0);
    chk("rst_ferr", {31'd0, frame_err_out}, 0);
    chk("rst_busy", {31'd0, busy_out}, 0);
    rst_n = 1'b1;
    idle_bits(2);

    align();
    send_frame(8'hA5, 1'b1, CPB * TCLK);
    idle_bits(2);
    lat = (ev_cyc.size() > 0) ? ev_cyc[0] - fall_cyc : -1;
    if (lat >= LAT - 1 && lat <= LAT + 1) lat = LAT;
    chk("latency", lat, LAT);
    drain("a5");

    align();
    send_frame(8'h00, 1'b1, CPB * TCLK);
    send_frame(8'hFF, 1'b1, CPB * TCLK);
    send_frame(8'h3C, 1'b1, CPB * TCLK);
    idle_bits(2);
    drain("b2b");

    align();
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #130;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #130;
    chk("glitch_busy", {31'd0, busy_out}, 0);
    drain("glitch");

    align();
    send_frame(8'h55, 1'b0, CPB * TCLK);
    repeat (40) @(posedge clk);
    #130;
    chk("brk_busy", {31'd0, busy_out}, 1);
    chk("brk_data", {24'd0, data_out}, {24'd0, last_good});
    rx = 1'b1;
    repeat (6) @(posedge clk);
    #130;
    chk("brk_idle", {31'd0, busy_out}, 0);
    align();
    send_frame(8'h12, 1'b1, CPB * TCLK);
    idle_bits(2);
    drain("ferr");

    align();
    b = 8'h81;
    rx = 1'b0;
    #(CPB * TCLK);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #(CPB * TCLK);
    end
    rx = b[4];
    #(CPB * TCLK / 2);
    rst_n = 1'b0;
    #(3 * TCLK);
    chk("mrst_data", {24'd0, data_out}, 0);
    chk("mrst_busy", {31'd0, busy_out}, 0);
    chk("mrst_strb", {30'd0, valid_out, frame_err_out}, 0);
    rx = 1'b1;
    #(TCLK);
    rst_n = 1'b1;
    last_good = 8'h00;
    idle_bits(2);
    align();
    send_frame(8'h42, 1'b1, CPB * TCLK);
    idle_bits(2);
    drain("mrst");

    for (int e = -30; e <= 30; e += 15) begin
      bt = CPB * TCLK * (1000 + e) / 1000;
      b = 8'($urandom);
      align();
      send_frame(b, 1'b1, bt);
      idle_bits(2);
    end
    drain("skew");

    align();
    for (int k = 0; k < 6; k++) send_frame(8'($urandom), 1'b1, CPB * TCLK);
    idle_bits(2);
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
